wr_pattern_gen: RTL

- User-side stimulus source that sits directly upstream of the write channel and drives its user_wr_* interface in the wr_clk domain.
- After DDR init completes, it emits a programmable number of fixed-length frames of counter or PRBS data.
- Frame start addresses step through a ring between a base and an end address.
- Used for AXI4 full-path write bring-up and soak testing; it self-stops when the write channel reports a FIFO error.

---
 rtl/wr_pattern_gen_if.sv | 24 ++
 rtl/wr_pattern_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wr_pattern_gen_if.sv
// User-side write bus driven by wr_pattern_gen toward the write channel.
interface wr_pattern_gen_if #(
    parameter int USER_DATA_WIDTH = 16,
    parameter int AXI_ADDR_WIDTH  = 32
);
    logic                       user_wr_mode;
    logic                       user_wr_en;
    logic                       user_wr_last;
    logic [USER_DATA_WIDTH-1:0] user_wr_data;
    logic [AXI_ADDR_WIDTH-1:0]  user_wr_addr;
    logic [12:0]                user_wr_length;
    logic [AXI_ADDR_WIDTH-1:0]  user_base_addr;
    logic [AXI_ADDR_WIDTH-1:0]  user_end_addr;

    modport master (
        output user_wr_mode, user_wr_en, user_wr_last, user_wr_data,
               user_wr_addr, user_wr_length, user_base_addr, user_end_addr
    );

    modport slave (
        input  user_wr_mode, user_wr_en, user_wr_last, user_wr_data,
               user_wr_addr, user_wr_length, user_base_addr, user_end_addr
    );
endinterface

// File: rtl/wr_pattern_gen.sv
// Frame-based write stimulus source (counter data, or LFSR data when WR_GEN_PRBS_EN is defined).
// Frames step through an address ring and the run stops on request, frame budget or FIFO error.
module wr_pattern_gen #(
    parameter int                        USER_DATA_WIDTH = 16,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        FRAME_LEN       = 1024,
    parameter int                        FRAME_GAP       = 16,
    parameter int                        FRAME_NUM       = 0,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] END_ADDR        = 32'h00FF_FFFF,
    parameter logic                      WR_MODE         = 1'b0
) (
    input  logic             wr_clk,
    input  logic             resetn,
    input  logic             ddr_init_done,
    input  logic             start,
    input  logic             stop,
    input  logic             cmd_fifo_err,
    input  logic             data_fifo_err,
    wr_pattern_gen_if.master wr,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [15:0]      frame_cnt
);
    localparam int AW2 = AXI_ADDR_WIDTH + 2;
    localparam int GW  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [AW2-1:0]  STEP         = AW2'(FRAME_LEN * USER_DATA_WIDTH / 8);
    localparam logic [12:0]     LAST_IDX     = 13'(FRAME_LEN - 1);
    localparam logic [GW-1:0]   GAP_LAST     = GW'(FRAME_GAP - 1);
    localparam logic [15:0]     FRAME_TARGET = 16'(FRAME_NUM);

    typedef enum logic [2:0] {IDLE, WAIT_INIT, SEND, GAP, DONE} state_t;

    state_t                    state, state_next;
    logic                      start_ok, frame_end, err_now, run_full;
    logic                      stop_pend;
    logic [12:0]               word_cnt;
    logic [GW-1:0]             gap_cnt;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr;

`ifdef WR_GEN_PRBS_EN
    logic [31:0] lfsr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction
`else
    logic [USER_DATA_WIDTH-1:0] data_cnt;
`endif

    // A frame may only start where it fits entirely at or below END_ADDR.
    function automatic logic [AXI_ADDR_WIDTH-1:0] ring_next(input logic [AXI_ADDR_WIDTH-1:0] cur);
        logic [AW2-1:0]            nxt;
        logic [AXI_ADDR_WIDTH-1:0] res;
        nxt = AW2'(cur) + STEP;
        if (nxt + STEP - AW2'(1) > AW2'(END_ADDR)) res = BASE_ADDR;
        else                                       res = nxt[AXI_ADDR_WIDTH-1:0];
        return res;
    endfunction

    assign wr.user_wr_mode   = WR_MODE;
    assign wr.user_wr_length = 13'(FRAME_LEN);
    assign wr.user_base_addr = BASE_ADDR;
    assign wr.user_end_addr  = END_ADDR;

    assign run_full = (FRAME_NUM != 0) && (frame_cnt + 16'd1 == FRAME_TARGET);

    always_ff @(posedge wr_clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        frame_end  = 1'b0;
        err_now    = err_flag | cmd_fifo_err | data_fifo_err;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = WAIT_INIT;
                    start_ok   = 1'b1;
                end
            end
            WAIT_INIT: begin
                if (stop || err_now)    state_next = DONE;
                else if (ddr_init_done) state_next = SEND;
            end
            SEND: begin
                if (word_cnt == LAST_IDX) begin
                    frame_end = 1'b1;
                    if (run_full || stop_pend || stop || err_now) state_next = DONE;
                    else if (FRAME_GAP == 0)                      state_next = SEND;
                    else                                          state_next = GAP;
                end
            end
            GAP: begin
                if (stop || err_now)          state_next = DONE;
                else if (gap_cnt == GAP_LAST) state_next = SEND;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs register the action of the state processed at each edge.
    always_ff @(posedge wr_clk or negedge resetn) begin
        if (!resetn) begin
            wr.user_wr_en   <= 1'b0;
            wr.user_wr_last <= 1'b0;
            wr.user_wr_data <= '0;
            wr.user_wr_addr <= BASE_ADDR;
            cur_addr        <= BASE_ADDR;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_flag        <= 1'b0;
            frame_cnt       <= 16'd0;
            stop_pend       <= 1'b0;
            word_cnt        <= 13'd0;
            gap_cnt         <= '0;
`ifdef WR_GEN_PRBS_EN
            lfsr            <= 32'h0000_0001;
`else
            data_cnt        <= '0;
`endif
        end else begin
            wr.user_wr_en   <= (state == SEND);
            wr.user_wr_last <= frame_end;
            done            <= (state == DONE);
            busy            <= (state == WAIT_INIT) || (state == SEND) || (state == GAP);
            word_cnt        <= (state == SEND && !frame_end) ? word_cnt + 13'd1 : 13'd0;
            gap_cnt         <= (state == GAP) ? gap_cnt + GW'(1) : '0;

            if (state == SEND) begin
`ifdef WR_GEN_PRBS_EN
                wr.user_wr_data <= lfsr[USER_DATA_WIDTH-1:0];
                lfsr            <= lfsr_step(lfsr);
`else
                wr.user_wr_data <= data_cnt;
                data_cnt        <= data_cnt + USER_DATA_WIDTH'(1);
`endif
            end

            // The visible address latches on the first word so it holds for the whole frame.
            if (state == SEND && word_cnt == 13'd0) wr.user_wr_addr <= cur_addr;
            if (frame_end) cur_addr <= ring_next(cur_addr);

            if (start_ok)       frame_cnt <= 16'd0;
            else if (frame_end) frame_cnt <= frame_cnt + 16'd1;

            if (start_ok || state == DONE)  stop_pend <= 1'b0;
            else if (state == SEND && stop) stop_pend <= 1'b1;

            if (cmd_fifo_err || data_fifo_err) err_flag <= 1'b1;
            else if (start_ok)                 err_flag <= 1'b0;
        end
    end
endmodule
